sa_output_deskew: RTL and testbench

SA_OUTPUT_DESKEW -- requirements
Module: sa_output_deskew

---
 rtl/sa_output_deskew.sv | 120 ++++++++++++
 tb/tb_sa_output_deskew.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_output_deskew.sv
// Deskews the staggered bottom-row partial sums of a systolic array and queues aligned rows in a small FIFO.
// Optional build macro SA_OUT_RELU_EN clamps negative column words to zero as rows enter the FIFO.
module sa_output_deskew #(
  parameter int ARR_WIDTH  = 8,
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WORD_WIDTH*4*ARR_WIDTH-1:0]   ps_in_vec,
  input  logic [ARR_WIDTH-1:0]                ps_valid_vec,
  input  logic                                clear,
  output logic [WORD_WIDTH*4*ARR_WIDTH-1:0]   row_out_vec,
  output logic                                row_valid,
  input  logic                                row_ready,
  output logic [$clog2(DEPTH):0]              fifo_count,
  output logic                                overflow,
  output logic                                align_err
);

  localparam int PSW  = WORD_WIDTH * 4;
  localparam int ROWW = PSW * ARR_WIDTH;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic [ROWW-1:0]      aligned_data;
  logic [ARR_WIDTH-1:0] aligned_valid;

  // Column c waits ARR_WIDTH-1-c cycles so every word of a row meets the last column.
  genvar c;
  for (c = 0; c < ARR_WIDTH; c++) begin : g_col
    localparam int D = ARR_WIDTH - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned_data[c*PSW +: PSW] = ps_in_vec[c*PSW +: PSW];
      assign aligned_valid[c]           = ps_valid_vec[c];
    end else begin : g_dly
      logic [PSW-1:0] d_q [D];
      logic [D-1:0]   v_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
        end else begin
          v_q[0] <= ps_valid_vec[c];
          for (int s = 1; s < D; s++) v_q[s] <= v_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        d_q[0] <= ps_in_vec[c*PSW +: PSW];
        for (int s = 1; s < D; s++) d_q[s] <= d_q[s-1];
      end

      assign aligned_data[c*PSW +: PSW] = d_q[D-1];
      assign aligned_valid[c]           = v_q[D-1];
    end
  end

  logic [ROWW-1:0]      cap_data;
  logic [ARR_WIDTH-1:0] cap_valid;

  always_ff @(posedge clk) begin
    if (reset) cap_valid <= '0;
    else       cap_valid <= aligned_valid;
  end

  always_ff @(posedge clk) begin
    cap_data <= aligned_data;
  end

  function automatic logic [ROWW-1:0] relu_row(input logic [ROWW-1:0] r);
    logic [ROWW-1:0] o;
    o = r;
`ifdef SA_OUT_RELU_EN
    for (int k = 0; k < ARR_WIDTH; k++)
      if (r[k*PSW + PSW - 1]) o[k*PSW +: PSW] = '0;
`endif
    return o;
  endfunction

  logic [ROWW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, push_req, push, drop, mixed;

  assign full      = (count == CW'(DEPTH));
  assign row_valid = (count != '0);
  assign pop       = row_valid & row_ready;
  assign push_req  = &cap_valid;
  // A full FIFO still accepts a row when the head leaves on the same edge.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign mixed     = (|cap_valid) & ~push_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop)       overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
      if (mixed)      align_err <= 1'b1;
      else if (clear) align_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= relu_row(cap_data);
  end

  assign row_out_vec = mem[rd_ptr];
  assign fifo_count  = count;

endmodule

// File: tb/tb_sa_output_deskew.sv
// Directed bench for sa_output_deskew (4 columns, 32-bit partial sums, 4-row FIFO).
// Expected ReLU results follow SA_OUT_RELU_EN when the bench is built with that macro.
module tb_sa_output_deskew;

  logic         clk;
  logic         reset;
  logic [127:0] ps_in_vec;
  logic [3:0]   ps_valid_vec;
  logic         clear;
  logic [127:0] row_out_vec;
  logic         row_valid;
  logic         row_ready;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic         align_err;

  int n_checks = 0;
  int n_pass   = 0;

  sa_output_deskew #(.ARR_WIDTH(4), .WORD_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps_in_vec(ps_in_vec), .ps_valid_vec(ps_valid_vec),
    .clear(clear), .row_out_vec(row_out_vec), .row_valid(row_valid),
    .row_ready(row_ready), .fifo_count(fifo_count), .overflow(overflow),
    .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w;
    logic [3:0]   vmask;
    logic         exp_push;
    logic         exp_err;
    logic [127:0] exp_row;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] rowWord(input logic [31:0] base, input int r);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = base + 32'(16*r + k);
    return v;
  endfunction

  // Drive one column word; the other columns carry junk with their valid bits low.
  task automatic driveCol(input int col, input logic [31:0] word, input logic v);
    ps_in_vec = {$urandom, $urandom, $urandom, $urandom};
    ps_in_vec[col*32 +: 32] = word;
    ps_valid_vec = '0;
    ps_valid_vec[col] = v;
  endtask

  task automatic applyStimulus(input logic [127:0] w, input logic [3:0] vmask);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      driveCol(k, w[k*32 +: 32], vmask[k]);
    end
  endtask

  task automatic streamRows(input int n, input logic [31:0] base, input logic ready);
    int got;
    logic [127:0] rw;
    got = 0;
    for (int t = 0; t < n + 7; t++) begin
      @(negedge clk);
      if (ready && row_valid) begin
        checkOutput($sformatf("stream_row%0d", got), row_out_vec, rowWord(base, got));
        checkOutput("stream_count_le1", {127'd0, fifo_count <= 3'd1}, 128'd1);
        got++;
      end
      row_ready = ready;
      ps_valid_vec = '0;
      for (int k = 0; k < 4; k++) begin
        if (t - k >= 0 && t - k < n) begin
          rw = rowWord(base, t - k);
          ps_in_vec[k*32 +: 32] = rw[k*32 +: 32];
          ps_valid_vec[k] = 1'b1;
        end else begin
          ps_in_vec[k*32 +: 32] = $urandom;
        end
      end
    end
    @(negedge clk);
    row_ready = 1'b0;
    ps_valid_vec = '0;
    if (ready) checkOutput("stream_total", 128'(got), 128'(n));
  endtask

  task automatic drainRows(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("drain_valid%0d", k), {127'd0, row_valid}, 128'd1);
      checkOutput($sformatf("drain_row%0d", k), row_out_vec, rowWord(base, k));
      row_ready = 1'b1;
      @(negedge clk);
    end
    row_ready = 1'b0;
    checkOutput("drain_empty_valid", {127'd0, row_valid}, 128'd0);
    checkOutput("drain_empty_count", 128'(fifo_count), 128'd0);
  endtask

  initial begin
    vecs[0] = '{w: {32'h13, 32'h12, 32'h11, 32'h10}, vmask: 4'hF, exp_push: 1'b1, exp_err: 1'b0,
                exp_row: {32'h13, 32'h12, 32'h11, 32'h10}};
`ifdef SA_OUT_RELU_EN
    vecs[1] = '{w: {32'h7FFFFFFF, 32'h80000000, 32'h00000005, 32'hFFFFFFF0}, vmask: 4'hF,
                exp_push: 1'b1, exp_err: 1'b0,
                exp_row: {32'h7FFFFFFF, 32'h00000000, 32'h00000005, 32'h00000000}};
`else
    vecs[1] = '{w: {32'h7FFFFFFF, 32'h80000000, 32'h00000005, 32'hFFFFFFF0}, vmask: 4'hF,
                exp_push: 1'b1, exp_err: 1'b0,
                exp_row: {32'h7FFFFFFF, 32'h80000000, 32'h00000005, 32'hFFFFFFF0}};
`endif
    vecs[2] = '{w: {32'h23, 32'h22, 32'h21, 32'h20}, vmask: 4'b1011, exp_push: 1'b0, exp_err: 1'b1,
                exp_row: 128'd0};
    vecs[3] = '{w: {32'h33, 32'h32, 32'h31, 32'h30}, vmask: 4'b0000, exp_push: 1'b0, exp_err: 1'b0,
                exp_row: 128'd0};
    vecs[4] = '{w: {32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'hAAAA5555}, vmask: 4'hF,
                exp_push: 1'b1, exp_err: 1'b0,
                exp_row: {32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'hAAAA5555}};
    vecs[5] = '{w: {32'h43, 32'h42, 32'h41, 32'h40}, vmask: 4'b0001, exp_push: 1'b0, exp_err: 1'b1,
                exp_row: 128'd0};

    reset = 1'b1;
    ps_in_vec = '0;
    ps_valid_vec = '0;
    clear = 1'b0;
    row_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_row_valid", {127'd0, row_valid}, 128'd0);
    checkOutput("reset_count", 128'(fifo_count), 128'd0);
    checkOutput("reset_overflow", {127'd0, overflow}, 128'd0);
    checkOutput("reset_align_err", {127'd0, align_err}, 128'd0);
    reset = 1'b0;

    // Single skewed rows: latency, all/none/mixed valid handling, ReLU, clear.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].w, vecs[i].vmask);
      @(negedge clk);
      ps_valid_vec = '0;
      checkOutput($sformatf("vec%0d_early_valid", i), {127'd0, row_valid}, 128'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), {127'd0, row_valid}, {127'd0, vecs[i].exp_push});
      checkOutput($sformatf("vec%0d_count", i), 128'(fifo_count), {127'd0, vecs[i].exp_push});
      checkOutput($sformatf("vec%0d_align_err", i), {127'd0, align_err}, {127'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_overflow", i), {127'd0, overflow}, 128'd0);
      if (vecs[i].exp_push) checkOutput($sformatf("vec%0d_row", i), row_out_vec, vecs[i].exp_row);
      row_ready = vecs[i].exp_push;
      clear = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      clear = 1'b0;
      checkOutput($sformatf("vec%0d_after_valid", i), {127'd0, row_valid}, 128'd0);
      checkOutput($sformatf("vec%0d_after_err", i), {127'd0, align_err}, 128'd0);
    end

    // A mixed row arriving while clear is held: the set must win.
    clear = 1'b1;
    applyStimulus(rowWord(32'h600, 0), 4'b0001);
    @(negedge clk);
    ps_valid_vec = '0;
    @(negedge clk);
    checkOutput("set_wins_over_clear", {127'd0, align_err}, 128'd1);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_after_set", {127'd0, align_err}, 128'd0);

    // Back-to-back rows with the consumer always ready.
    streamRows(6, 32'h200, 1'b1);
    checkOutput("stream_overflow", {127'd0, overflow}, 128'd0);

    // Five rows into a four-row FIFO with no consumer.
    streamRows(5, 32'h300, 1'b0);
    checkOutput("ovf_count", 128'(fifo_count), 128'd4);
    checkOutput("ovf_flag", {127'd0, overflow}, 128'd1);
    drainRows(4, 32'h300);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("ovf_cleared", {127'd0, overflow}, 128'd0);

    // Full FIFO accepting a push on the same edge as a pop.
    streamRows(4, 32'h400, 1'b0);
    applyStimulus(rowWord(32'h400, 4), 4'hF);
    @(negedge clk);
    ps_valid_vec = '0;
    checkOutput("fullpop_count_before", 128'(fifo_count), 128'd4);
    checkOutput("fullpop_head_before", row_out_vec, rowWord(32'h400, 0));
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    checkOutput("fullpop_count_after", 128'(fifo_count), 128'd4);
    checkOutput("fullpop_overflow", {127'd0, overflow}, 128'd0);
    drainRows(4, 32'h410);

    // Reset while a row is half-way through the deskew lines, with one row queued.
    applyStimulus(rowWord(32'h500, 0), 4'hF);
    @(negedge clk);
    ps_valid_vec = '0;
    @(negedge clk);
    checkOutput("prereset_count", 128'(fifo_count), 128'd1);
    @(negedge clk);
    driveCol(0, 32'h510, 1'b1);
    @(negedge clk);
    driveCol(1, 32'h511, 1'b1);
    @(negedge clk);
    driveCol(2, 32'h512, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ps_valid_vec = '0;
    checkOutput("midreset_valid", {127'd0, row_valid}, 128'd0);
    checkOutput("midreset_count", 128'(fifo_count), 128'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("postreset_valid%0d", k), {127'd0, row_valid}, 128'd0);
    end
    checkOutput("postreset_align_err", {127'd0, align_err}, 128'd0);
    checkOutput("postreset_count", 128'(fifo_count), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
